branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Successor to the EX-stage branch resolver: adds a direct-mapped BTB with per-entry saturating direction counters, queried in IF and trained from EX.
- Resolves branch/JAL/JALR in EX, including the correct JALR target, and checks the result against the prediction carried down the pipe.
- Raises pc_src/flush/new_pc only on a mispredict; keeps a mispredict counter for perf monitoring.

Parameters:
- XLEN, 32, datapath and PC width.
- BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2. IDX_W = log2(BTB_ENTRIES).
- CNT_W, 2, direction counter width; at least 1. Prediction is the counter MSB.
- CTRL_W, `CONTROL_SIGNALS_WIDTH, width of the control bundle.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- if_pc  in  XLEN  fetch PC to look up
- if_pred_taken  out  1  prediction for if_pc
- if_pred_target  out  XLEN  predicted target; if_pc+4 when not predicted taken
- ex_valid  in  1  EX holds a real (non-bubble, non-stalled) instruction
- ex_pc, ex_instruction, ex_rs1_data, ex_rs2_data, ex_immediate  in  XLEN each  EX operands
- ex_control_signals  in  CTRL_W  uses `CTRL_BRANCH and `CTRL_JUMP
- ex_pred_taken  in  1  prediction carried from IF
- ex_pred_target  in  XLEN  prediction carried from IF
- pc_src  out  1  redirect fetch
- new_pc  out  XLEN  redirect address
- flush  out  1  squash younger stages
- mispredict_count  out  32  saturating count of mispredicts

Behaviour:
- Indexing: index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
- Each entry holds valid, tag, target, is_jump and a CNT_W counter.
- Lookup is combinational from registered state. hit = valid & tag match.
  - if_pred_taken = hit & (is_jump | cnt[MSB]).
  - if_pred_target = the entry's target when predicted taken, else if_pc+4.
- Resolution is combinational and qualified by ex_valid. Branch or jump with neither flag set: no resolution.
  - Branch: taken per funct3, using `BRANCH_EQ/NE/LT/GE/LTU/GEU. The two signed compares are signed; the U compares are unsigned. Any other funct3 is not taken. Target = ex_pc+imm.
  - Jump: always taken. JALR (opcode `OPCODE_JALR) target = (rs1+imm) & ~1. JAL target = ex_pc+imm.
  - All additions wrap modulo 2^XLEN.
- Mispredict = (taken != ex_pred_taken) | (taken & target != ex_pred_target).
  - On mispredict: pc_src = flush = 1; new_pc = target if taken, else ex_pc+4.
  - Otherwise pc_src = flush = 0 and new_pc = 0.
- Update happens at the posedge when ex_valid & (branch | jump).
  - Hit: counter +1 if taken, -1 if not, saturating at 0 and at 2^CNT_W-1. On taken, target is rewritten. is_jump is rewritten.
  - Miss and taken: allocate (overwrite) the entry. valid = 1, tag, target, is_jump set; counter = weakly taken (MSB=1, other bits 0).
  - Miss and not taken: no allocation.
- mispredict_count increments on each mispredict resolution and saturates at 32'hFFFF_FFFF.
- Same-cycle lookup and update of one index: the lookup returns the pre-update contents; the new contents are visible next cycle.
- If both `CTRL_BRANCH and `CTRL_JUMP are set, the branch wins, as in the previous unit.
- Reset (async assert, sync deassert handled upstream): all valid = 0, counters = weakly not-taken (MSB=0, others 1), targets and tags = 0, mispredict_count = 0.
  - Output values during reset: if_pred_taken = 0, if_pred_target = if_pc+4; combinational EX outputs follow their inputs.
  - Reset in mid-operation discards all training.

Decomposition:
- Shared constants in constants.v: `BRANCH_* funct3 codes, `OPCODE_JALR, `CTRL_BRANCH, `CTRL_JUMP, `CONTROL_SIGNALS_WIDTH.
- One sub-module: branch_resolve. Combinational; takes the EX operands and produces taken and target. It is reusable by a future second EX lane.
- Table storage and the counters stay in the top block.

Test Plan:
- Reset, then beq at pc 0x100, imm 0x20, rs1 = rs2 = 5, pred_taken 0 -> pc_src = flush = 1, new_pc = 0x120. Next cycle, if_pc = 0x100 gives if_pred_taken = 1, target 0x120. mispredict_count = 1.
- Same beq resolved taken 3 more times with matching prediction -> no flush; counter saturates at 3. Then resolved not-taken -> flush, new_pc = 0x104, counter = 2, prediction still taken.
- JALR at 0x200, rs1 = 0x1001, imm = 4 -> target 0x1004 (bit0 cleared). After training, a mismatched ex_pred_target of 0x1000 -> flush, new_pc = 0x1004.
- bltu with rs1 = 0xFFFF_FFFF, rs2 = 1 -> not taken; blt with the same operands -> taken. Not-taken miss allocates nothing: a lookup of that pc gives if_pred_taken = 0.
- Aliasing: BTB_ENTRIES = 16, pcs 0x100 and 0x140 share index 0 -> training 0x140 evicts 0x100. A lookup of 0x100 misses. Lookup and update of index 0 in the same cycle return the old entry.
- Assert rst_n low mid-stream after training -> next cycle's lookups all miss and mispredict_count = 0. ex_valid = 0 with a branch present -> no flush, no update.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings and helpers for the branch predict unit and its EX resolver.
// The macros are the shared funct3/opcode/control-bundle constants used across the core.
`ifndef BRANCH_PREDICT_CONSTANTS
`define BRANCH_PREDICT_CONSTANTS
`define BRANCH_EQ  3'b000
`define BRANCH_NE  3'b001
`define BRANCH_LT  3'b100
`define BRANCH_GE  3'b101
`define BRANCH_LTU 3'b110
`define BRANCH_GEU 3'b111
`define OPCODE_JALR 7'b1100111
`define CTRL_BRANCH 0
`define CTRL_JUMP   1
`define CONTROL_SIGNALS_WIDTH 8
`endif

package branch_predict_unit_pkg;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_BRANCH = 2'd1,
    RES_JUMP   = 2'd2
  } res_kind_e;

  localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == PERF_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational EX-stage resolution of a branch or jump: taken flag and target.
module branch_resolve
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  res_kind_e        kind,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  instruction,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  immediate,
  output logic             taken,
  output logic [XLEN-1:0]  target
);

  logic [2:0] funct3;
  logic [6:0] opcode;
  logic       unused_instr;

  assign funct3       = instruction[14:12];
  assign opcode       = instruction[6:0];
  assign unused_instr = ^{instruction[XLEN-1:15], instruction[11:7]};

  always_comb begin
    taken  = 1'b0;
    target = pc + immediate;
    case (kind)
      RES_BRANCH: begin
        case (funct3)
          `BRANCH_EQ:  taken = (rs1_data == rs2_data);
          `BRANCH_NE:  taken = (rs1_data != rs2_data);
          `BRANCH_LT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
          `BRANCH_GE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
          `BRANCH_LTU: taken = (rs1_data <  rs2_data);
          `BRANCH_GEU: taken = (rs1_data >= rs2_data);
          default:     taken = 1'b0;
        endcase
      end
      RES_JUMP: begin
        taken = 1'b1;
        // JALR drops bit 0 of the computed address; JAL is PC-relative
        if (opcode == `OPCODE_JALR)
          target = (rs1_data + immediate) & ~XLEN'(1);
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with saturating direction counters, looked up in IF and
// trained from EX, plus EX-stage mispredict detection and redirect.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_W       = 2,
  parameter int CTRL_W      = `CONTROL_SIGNALS_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  output logic [XLEN-1:0]   if_pred_target,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_instruction,
  input  logic [XLEN-1:0]   ex_rs1_data,
  input  logic [XLEN-1:0]   ex_rs2_data,
  input  logic [XLEN-1:0]   ex_immediate,
  input  logic [CTRL_W-1:0] ex_control_signals,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   ex_pred_target,
  output logic              pc_src,
  output logic [XLEN-1:0]   new_pc,
  output logic              flush,
  output logic [31:0]       mispredict_count
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]  target_q [BTB_ENTRIES];
  logic             jump_q   [BTB_ENTRIES];
  logic [CNT_W-1:0] cnt_q    [BTB_ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  res_kind_e        kind;
  logic             res_taken, mispredict;
  logic [XLEN-1:0]  res_target;
  logic             unused_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[XLEN-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX_W+2];
  assign unused_bits = ^{if_pc[1:0], ex_pc[1:0], ex_control_signals};

  assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign if_pred_taken  = if_hit && (jump_q[if_idx] || cnt_q[if_idx][CNT_W-1]);
  assign if_pred_target = if_pred_taken ? target_q[if_idx] : if_pc + XLEN'(4);

  // Branch takes priority when both control bits are set
  always_comb begin
    kind = RES_NONE;
    if (ex_valid && ex_control_signals[`CTRL_BRANCH])
      kind = RES_BRANCH;
    else if (ex_valid && ex_control_signals[`CTRL_JUMP])
      kind = RES_JUMP;
  end

  branch_resolve #(.XLEN(XLEN)) u_resolve (
    .kind        (kind),
    .pc          (ex_pc),
    .instruction (ex_instruction),
    .rs1_data    (ex_rs1_data),
    .rs2_data    (ex_rs2_data),
    .immediate   (ex_immediate),
    .taken       (res_taken),
    .target      (res_target)
  );

  assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign mispredict = (kind != RES_NONE) &&
                      ((res_taken != ex_pred_taken) ||
                       (res_taken && (res_target != ex_pred_target)));
  assign pc_src = mispredict;
  assign flush  = mispredict;
  assign new_pc = !mispredict ? '0 : (res_taken ? res_target : ex_pc + XLEN'(4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        jump_q[i]   <= 1'b0;
        cnt_q[i]    <= CNT_WNT;
      end
      mispredict_count <= '0;
    end else begin
      if (kind != RES_NONE) begin
        if (ex_hit) begin
          if (res_taken) begin
            target_q[ex_idx] <= res_target;
            if (cnt_q[ex_idx] != CNT_MAX) cnt_q[ex_idx] <= cnt_q[ex_idx] + CNT_W'(1);
          end else if (cnt_q[ex_idx] != '0) begin
            cnt_q[ex_idx] <= cnt_q[ex_idx] - CNT_W'(1);
          end
          jump_q[ex_idx] <= (kind == RES_JUMP);
        end else if (res_taken) begin
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= ex_tag;
          target_q[ex_idx] <= res_target;
          jump_q[ex_idx]   <= (kind == RES_JUMP);
          cnt_q[ex_idx]    <= CNT_WT;
        end
      end
      if (mispredict) mispredict_count <= sat_inc32(mispredict_count);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed-vector bench for branch_predict_unit with a queue-based scoreboard.
module tb_branch_predict_unit;

  localparam logic [7:0]  B = 8'h01;
  localparam logic [7:0]  J = 8'h02;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] BNE  = 32'h0000_1063;
  localparam logic [31:0] BLT  = 32'h0000_4063;
  localparam logic [31:0] BGE  = 32'h0000_5063;
  localparam logic [31:0] BLTU = 32'h0000_6063;
  localparam logic [31:0] BGEU = 32'h0000_7063;
  localparam logic [31:0] JALR = 32'h0000_0067;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] M1   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_instruction, ex_rs1_data, ex_rs2_data, ex_immediate;
  logic [7:0]  ex_control_signals;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        pc_src;
  logic [31:0] new_pc;
  logic        flush;
  logic [31:0] mispredict_count;

  always #5 clk = ~clk;

  branch_predict_unit #(.XLEN(32), .BTB_ENTRIES(16), .CNT_W(2), .CTRL_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instruction(ex_instruction),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_immediate(ex_immediate),
    .ex_control_signals(ex_control_signals),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc_src(pc_src), .new_pc(new_pc), .flush(flush),
    .mispredict_count(mispredict_count)
  );

  typedef struct {
    bit          rst;
    bit          v;
    logic [7:0]  ctrl;
    logic [31:0] pc, ins, rs1, rs2, imm;
    bit          pt;
    logic [31:0] ptg, ifpc;
    bit          e_redir;
    logic [31:0] e_npc;
    bit          e_pt;
    logic [31:0] e_ptg, e_cnt;
  } vec_t;

  typedef struct {
    int          step;
    bit          redir;
    logic [31:0] npc;
    bit          pt;
    logic [31:0] ptg, cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input bit rst, input bit v, input logic [7:0] ctrl,
                     input logic [31:0] pc, input logic [31:0] ins,
                     input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                     input bit pt, input logic [31:0] ptg, input logic [31:0] ifpc,
                     input bit er, input logic [31:0] enpc, input bit ept,
                     input logic [31:0] eptg, input logic [31:0] ecnt);
    vec_t t;
    t.rst = rst; t.v = v; t.ctrl = ctrl; t.pc = pc; t.ins = ins;
    t.rs1 = rs1; t.rs2 = rs2; t.imm = imm; t.pt = pt; t.ptg = ptg; t.ifpc = ifpc;
    t.e_redir = er; t.e_npc = enpc; t.e_pt = ept; t.e_ptg = eptg; t.e_cnt = ecnt;
    vecs.push_back(t);
  endtask

  task automatic idle(input bit rst, input logic [31:0] ifpc, input bit ept,
                      input logic [31:0] eptg, input logic [31:0] ecnt);
    add(rst, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, ifpc, 0, 0, ept, eptg, ecnt);
  endtask

  task automatic check(input string nm, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every driven cycle presents a result
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("pc_src",           e.step, {31'b0, pc_src},        {31'b0, e.redir});
      check("flush",            e.step, {31'b0, flush},         {31'b0, e.redir});
      check("new_pc",           e.step, new_pc,                 e.npc);
      check("if_pred_taken",    e.step, {31'b0, if_pred_taken}, {31'b0, e.pt});
      check("if_pred_target",   e.step, if_pred_target,         e.ptg);
      check("mispredict_count", e.step, mispredict_count,       e.cnt);
    end
  end

  initial begin
    // step 0: held in reset, EX outputs still follow inputs, no training
    add(0,1,B,32'h100,BEQ,5,5,32'h20,0,0,32'h100, 1,32'h120,0,32'h104,0);
    // 1..4: allocate beq 0x100 then saturate the counter
    add(1,1,B,32'h100,BEQ,5,5,32'h20,0,0,32'h100, 1,32'h120,0,32'h104,0);
    add(1,1,B,32'h100,BEQ,5,5,32'h20,1,32'h120,32'h100, 0,0,1,32'h120,1);
    add(1,1,B,32'h100,BEQ,5,5,32'h20,1,32'h120,32'h100, 0,0,1,32'h120,1);
    add(1,1,B,32'h100,BEQ,5,5,32'h20,1,32'h120,32'h100, 0,0,1,32'h120,1);
    // 5..11: walk the counter down to 0 and back up
    add(1,1,B,32'h100,BEQ,5,6,32'h20,1,32'h120,32'h100, 1,32'h104,1,32'h120,1);
    idle(1,32'h100,1,32'h120,2);
    add(1,1,B,32'h100,BEQ,5,6,32'h20,1,32'h120,32'h100, 1,32'h104,1,32'h120,2);
    add(1,1,B,32'h100,BEQ,5,6,32'h20,0,0,32'h100, 0,0,0,32'h104,3);
    add(1,1,B,32'h100,BEQ,5,6,32'h20,0,0,32'h100, 0,0,0,32'h104,3);
    add(1,1,B,32'h100,BEQ,5,5,32'h20,0,0,32'h100, 1,32'h120,0,32'h104,3);
    add(1,1,B,32'h100,BEQ,5,5,32'h20,0,0,32'h100, 1,32'h120,0,32'h104,4);
    idle(1,32'h100,1,32'h120,5);
    // 13..15: JAL at 0x140 aliases index 0; same-cycle lookup sees old entry
    add(1,1,J,32'h140,JAL,0,0,32'h40,0,0,32'h100, 1,32'h180,1,32'h120,5);
    idle(1,32'h100,0,32'h104,6);
    idle(1,32'h140,1,32'h180,6);
    // 16..21: compare flavours
    add(1,1,B,32'h184,BLTU,M1,1,32'h10,0,0,32'h184, 0,0,0,32'h188,6);
    idle(1,32'h184,0,32'h188,6);
    add(1,1,B,32'h188,BLT,M1,1,32'h40,0,0,32'h184, 1,32'h1C8,0,32'h188,6);
    add(1,1,B,32'h18C,BGEU,M1,1,32'hFFFF_FFF8,0,0,32'h188, 1,32'h184,1,32'h1C8,7);
    add(1,1,B,32'h190,BGE,M1,1,32'h10,0,0,32'h18C, 0,0,1,32'h184,8);
    add(1,1,B,32'h194,BNE,5,5,32'h10,0,0,32'h190, 0,0,0,32'h194,8);
    // 22..24: JALR target with bit 0 cleared, then wrong/right predicted target
    add(1,1,J,32'h200,JALR,32'h1001,0,4,0,0,32'h200, 1,32'h1004,0,32'h204,8);
    add(1,1,J,32'h200,JALR,32'h1001,0,4,1,32'h1000,32'h200, 1,32'h1004,1,32'h1004,9);
    add(1,1,J,32'h200,JALR,32'h1001,0,4,1,32'h1004,32'h200, 0,0,1,32'h1004,10);
    // 25: branch wins over jump; 26: ex_valid low suppresses everything
    add(1,1,B|J,32'h300,BEQ,5,6,32'h20,0,0,32'h200, 0,0,1,32'h1004,10);
    add(1,0,B,32'h304,BEQ,5,5,32'h20,0,0,32'h300, 0,0,0,32'h304,10);
    idle(1,32'h304,0,32'h308,10);
    // 28..30: mid-stream reset discards all training
    idle(0,32'h200,0,32'h204,0);
    idle(1,32'h188,0,32'h18C,0);
    idle(1,32'h140,0,32'h144,0);

    rst_n = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_instruction = '0;
    ex_rs1_data = '0; ex_rs2_data = '0; ex_immediate = '0; ex_control_signals = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      rst_n = vecs[i].rst; ex_valid = vecs[i].v; ex_control_signals = vecs[i].ctrl;
      ex_pc = vecs[i].pc; ex_instruction = vecs[i].ins;
      ex_rs1_data = vecs[i].rs1; ex_rs2_data = vecs[i].rs2; ex_immediate = vecs[i].imm;
      ex_pred_taken = vecs[i].pt; ex_pred_target = vecs[i].ptg; if_pc = vecs[i].ifpc;
      e.step = i; e.redir = vecs[i].e_redir; e.npc = vecs[i].e_npc;
      e.pt = vecs[i].e_pt; e.ptg = vecs[i].e_ptg; e.cnt = vecs[i].e_cnt;
      sb.push_back(e);
      @(posedge clk); #1;
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
